red_pitaya_avg_block: RTL and testbench
=======================================

# red_pitaya_avg_block

- DSP submodule that plugs into one module slot of the DSP routing bus.
- Consumes the slot's selected `input_signal` and averages a programmable power-of-two number of samples, one-shot or continuously.
- Tracks the window minimum and maximum.
- Exposes the mean on `dat_o` as the slot's `output_direct`/`output_signal`, and all results as registers on the slot's 64 KiB bus window.

## Interface
Parameters:
- `SIGNALBITS`, 14, width of `dat_i`/`dat_o` (signed two's complement)
- `LOG_MAX_AVG`, 16, maximum log2 of window length
- `ACCBITS`, `SIGNALBITS+LOG_MAX_AVG`, accumulator width (derived, not overridden)

Ports:
- `clk_i` in 1: processing clock; one clock, all logic on rising edge.
- `rst_i` in 1: reset; synchronous, active-high.
- `dat_i` in SIGNALBITS: signed input sample, one per cycle.
- `trig_i` in 1: external start pulse (e.g. scope trigger), level sampled.
- `dat_o` out SIGNALBITS: last completed mean.
- `addr` in 16: bus offset within slot.
- `wen` in 1: bus write strobe (slot-qualified).
- `ren` in 1: bus read strobe (slot-qualified).
- `wdata` in 32: bus write data.
- `rdata` out 32: bus read data.
- `ack` out 1: bus acknowledge.

## Operation
Register map (offsets 0x000–0x00F are reserved by the parent and never decoded):
- 0x100 CTRL, write:
  - bit0 start (strobe)
  - bit1 continuous
  - bit2 abort (strobe)
  - bit3 trig_en
- 0x100 CTRL, read: {28'b0, trig_en, done, continuous, busy}.
- 0x104 LOG2N [4:0]: written values above LOG_MAX_AVG clamp to LOG_MAX_AVG.
- 0x108 MEAN: sign-extended to 32 bit; a read clears done.
- 0x10C MIN, 0x110 MAX: sign-extended.
- 0x114 SUM_LO: bits [31:0] of the sum.
- 0x118 SUM_HI: remaining sum bits, sign-extended.
- 0x11C COUNT [15:0]: completed windows, wraps 0xFFFF→0.

State machine, IDLE / ACQ:
- IDLE→ACQ: start strobe, or trig_i=1 while trig_en=1.
- On entry:
  - latch LOG2N into shadow n_sh
  - clear accumulator and sample counter
  - min←+2^(SIGNALBITS-1)-1, max←−2^(SIGNALBITS-1)
- ACQ: each edge adds `dat_i` (sign-extended to ACCBITS) to acc, updates min/max, increments counter.
- Nth sample (N=2^n_sh):
  - MEAN←(acc+dat_i)>>>n_sh (arithmetic shift, floor), SUM←acc+dat_i, MIN/MAX final
  - done←1, COUNT++
- After the Nth sample: continuous=1 → re-enter ACQ with no gap sample; else → IDLE.
- Abort: →IDLE next edge, partial window discarded, result registers and COUNT unchanged. Abort wins over a simultaneous start.
- Start or trigger while busy: ignored.
- LOG2N write while busy: affects the next window only.
- done set and MEAN read in the same cycle: set wins.

Arithmetic:
- ACCBITS is sufficient for 2^LOG_MAX_AVG full-scale samples; no overflow is possible.
- Mean always fits SIGNALBITS; no saturation needed.

## Timing
- Sample window: the N `dat_i` values present at the N rising edges following the edge that accepted start.
- Results, `dat_o`, done, COUNT update on the edge of the Nth sample; visible in the following cycle.
- Bus: `ack` asserts one cycle after `wen|ren` for any offset ≥0x100; `rdata` is valid in the same cycle as `ack`. Unmapped offsets ack with rdata=0.
- Reset values:
  - `dat_o`=0, `rdata`=0, `ack`=0
  - state IDLE
  - all result registers, COUNT, LOG2N and CTRL bits = 0
- Reset mid-window aborts without updating results.

## Configuration
- `AVG_MINMAX_EN` defined: min/max tracking is built.
- Not defined: min/max logic is removed and MIN/MAX read 0. All other behaviour is identical.

## Test plan
- Constant `dat_i`=1000, LOG2N=4, start: after 16 sample edges → done=1, MEAN=1000, SUM_LO=16000, MIN=MAX=1000, COUNT=1, `dat_o`=1000.
- Ramp −8..7 over 16 samples → SUM=−8, MEAN=−1 (floor), MIN=−8, MAX=7.
- `dat_i`=−8192, LOG2N=16 → SUM_LO=0xE0000000, SUM_HI=0xFFFFFFFF, MEAN=−8192; no wrap. Writing LOG2N=20 reads back 16.
- Abort at sample 5 of 16 → busy=0 next cycle; MEAN/SUM/COUNT keep previous values; start in same cycle as abort ignored.
- Continuous, LOG2N=0 → `dat_o` follows `dat_i` one cycle late, COUNT increments every cycle and wraps 0xFFFF→0x0000.
- trig_en=1, `trig_i` pulse → window starts next edge. `rst_i` asserted at sample 3 → all outputs and registers 0, state IDLE.

Source files
------------

// File: rtl/red_pitaya_avg_block.sv
// red_pitaya_avg_block: power-of-two window averager for one DSP bus slot (mean, sum, window count).
// Optional feature: define AVG_MINMAX_EN to build the window min/max trackers; otherwise MIN/MAX read 0.
module red_pitaya_avg_block #(
  parameter int SIGNALBITS  = 14,
  parameter int LOG_MAX_AVG = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic signed [SIGNALBITS-1:0] dat_i,
  input  logic                         trig_i,
  output logic signed [SIGNALBITS-1:0] dat_o,
  input  logic [15:0]                  addr,
  input  logic                         wen,
  input  logic                         ren,
  input  logic [31:0]                  wdata,
  output logic [31:0]                  rdata,
  output logic                         ack
);

  localparam int ACCBITS = SIGNALBITS + LOG_MAX_AVG;

  localparam logic [15:0] A_CTRL   = 16'h0100;
  localparam logic [15:0] A_LOG2N  = 16'h0104;
  localparam logic [15:0] A_MEAN   = 16'h0108;
  localparam logic [15:0] A_MIN    = 16'h010C;
  localparam logic [15:0] A_MAX    = 16'h0110;
  localparam logic [15:0] A_SUM_LO = 16'h0114;
  localparam logic [15:0] A_SUM_HI = 16'h0118;
  localparam logic [15:0] A_COUNT  = 16'h011C;

  typedef enum logic {S_IDLE, S_ACQ} state_t;

  state_t                       r_state;
  logic                         r_cont;
  logic                         r_trig_en;
  logic                         r_done;
  logic [4:0]                   r_log2n;
  logic [4:0]                   r_n_sh;
  logic signed [ACCBITS-1:0]    r_acc;
  logic signed [ACCBITS-1:0]    r_sum;
  logic [LOG_MAX_AVG-1:0]       r_cnt;
  logic signed [SIGNALBITS-1:0] r_mean;
  logic [15:0]                  r_count;
  logic [31:0]                  r_rdata;
  logic                         r_ack;

  logic                         w_wr_ctrl;
  logic                         w_wr_log2n;
  logic                         w_start;
  logic                         w_abort;
  logic                         w_go;
  logic                         w_last;
  logic                         w_win_end;
  logic [LOG_MAX_AVG:0]         w_n;
  logic [4:0]                   w_log2n_clamped;
  logic signed [ACCBITS-1:0]    w_dat_ext;
  logic signed [ACCBITS-1:0]    w_sum;
  logic signed [ACCBITS-1:0]    w_mean_full;
  logic signed [SIGNALBITS-1:0] w_mean;
  logic [63:0]                  w_sum_ext;
  logic signed [SIGNALBITS-1:0] w_min_rd;
  logic signed [SIGNALBITS-1:0] w_max_rd;
  logic [31:0]                  w_rd_data;
  logic                         w_unused_mean;

  assign w_wr_ctrl  = wen && (addr == A_CTRL);
  assign w_wr_log2n = wen && (addr == A_LOG2N);
  assign w_start    = w_wr_ctrl && wdata[0];
  assign w_abort    = w_wr_ctrl && wdata[2];

  // Abort suppresses a start carried in the same CTRL write.
  assign w_go = (r_state == S_IDLE) && !w_abort && (w_start || (r_trig_en && trig_i));

  assign w_log2n_clamped = (wdata > 32'(LOG_MAX_AVG)) ? 5'(LOG_MAX_AVG) : wdata[4:0];

  assign w_n       = (LOG_MAX_AVG+1)'(1) << r_n_sh;
  assign w_last    = ({1'b0, r_cnt} == (w_n - (LOG_MAX_AVG+1)'(1)));
  assign w_win_end = (r_state == S_ACQ) && !w_abort && w_last;

  assign w_dat_ext     = {{LOG_MAX_AVG{dat_i[SIGNALBITS-1]}}, dat_i};
  assign w_sum         = r_acc + w_dat_ext;
  assign w_mean_full   = w_sum >>> r_n_sh;
  assign w_mean        = w_mean_full[SIGNALBITS-1:0];
  assign w_unused_mean = ^w_mean_full[ACCBITS-1:SIGNALBITS];
  assign w_sum_ext     = {{(64-ACCBITS){r_sum[ACCBITS-1]}}, r_sum};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_cont    <= 1'b0;
      r_trig_en <= 1'b0;
      r_done    <= 1'b0;
      r_log2n   <= '0;
      r_n_sh    <= '0;
      r_acc     <= '0;
      r_sum     <= '0;
      r_cnt     <= '0;
      r_mean    <= '0;
      r_count   <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_cont    <= wdata[1];
        r_trig_en <= wdata[3];
      end
      if (w_wr_log2n)
        r_log2n <= w_log2n_clamped;
      if (ren && (addr == A_MEAN))
        r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_state <= S_ACQ;
            r_n_sh  <= r_log2n;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        S_ACQ: begin
          if (w_abort) begin
            r_state <= S_IDLE;
          end else if (w_last) begin
            r_mean  <= w_mean;
            r_sum   <= w_sum;
            r_done  <= 1'b1;
            r_count <= r_count + 16'd1;
            // Continuous mode re-arms on the same edge so no sample is skipped.
            if (r_cont) begin
              r_n_sh <= r_log2n;
              r_acc  <= '0;
              r_cnt  <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + LOG_MAX_AVG'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef AVG_MINMAX_EN
  localparam logic signed [SIGNALBITS-1:0] MIN_INIT = {1'b0, {(SIGNALBITS-1){1'b1}}};
  localparam logic signed [SIGNALBITS-1:0] MAX_INIT = {1'b1, {(SIGNALBITS-1){1'b0}}};

  logic signed [SIGNALBITS-1:0] r_run_min;
  logic signed [SIGNALBITS-1:0] r_run_max;
  logic signed [SIGNALBITS-1:0] r_min;
  logic signed [SIGNALBITS-1:0] r_max;
  logic signed [SIGNALBITS-1:0] w_min_nxt;
  logic signed [SIGNALBITS-1:0] w_max_nxt;

  assign w_min_nxt = (dat_i < r_run_min) ? dat_i : r_run_min;
  assign w_max_nxt = (dat_i > r_run_max) ? dat_i : r_run_max;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_run_min <= '0;
      r_run_max <= '0;
      r_min     <= '0;
      r_max     <= '0;
    end else begin
      if (w_win_end) begin
        r_min <= w_min_nxt;
        r_max <= w_max_nxt;
      end
      if (w_go || (w_win_end && r_cont)) begin
        r_run_min <= MIN_INIT;
        r_run_max <= MAX_INIT;
      end else if ((r_state == S_ACQ) && !w_abort) begin
        r_run_min <= w_min_nxt;
        r_run_max <= w_max_nxt;
      end
    end
  end

  assign w_min_rd = r_min;
  assign w_max_rd = r_max;
`else
  assign w_min_rd = '0;
  assign w_max_rd = '0;
`endif

  always_comb begin
    w_rd_data = '0;
    case (addr)
      A_CTRL:   w_rd_data = {28'b0, r_trig_en, r_done, r_cont, (r_state == S_ACQ)};
      A_LOG2N:  w_rd_data = {27'b0, r_log2n};
      A_MEAN:   w_rd_data = {{(32-SIGNALBITS){r_mean[SIGNALBITS-1]}}, r_mean};
      A_MIN:    w_rd_data = {{(32-SIGNALBITS){w_min_rd[SIGNALBITS-1]}}, w_min_rd};
      A_MAX:    w_rd_data = {{(32-SIGNALBITS){w_max_rd[SIGNALBITS-1]}}, w_max_rd};
      A_SUM_LO: w_rd_data = w_sum_ext[31:0];
      A_SUM_HI: w_rd_data = w_sum_ext[63:32];
      A_COUNT:  w_rd_data = {16'b0, r_count};
      default:  w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= (wen || ren) && (addr >= 16'h0100);
      r_rdata <= (ren && (addr >= 16'h0100)) ? w_rd_data : '0;
    end
  end

  assign dat_o = r_mean;
  assign rdata = r_rdata;
  assign ack   = r_ack;

endmodule

// File: tb/tb_red_pitaya_avg_block.sv
// Directed self-checking bench for red_pitaya_avg_block; honours AVG_MINMAX_EN for MIN/MAX expectations.
module tb_red_pitaya_avg_block;

  localparam logic [15:0] A_CTRL   = 16'h0100;
  localparam logic [15:0] A_LOG2N  = 16'h0104;
  localparam logic [15:0] A_MEAN   = 16'h0108;
  localparam logic [15:0] A_MIN    = 16'h010C;
  localparam logic [15:0] A_MAX    = 16'h0110;
  localparam logic [15:0] A_SUM_LO = 16'h0114;
  localparam logic [15:0] A_SUM_HI = 16'h0118;
  localparam logic [15:0] A_COUNT  = 16'h011C;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic signed [13:0] dat_i;
  logic               trig_i;
  logic signed [13:0] dat_o;
  logic [15:0]        addr;
  logic               wen;
  logic               ren;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               ack;

  int errors = 0;
  int checks = 0;
  logic [31:0] d;

  red_pitaya_avg_block #(.SIGNALBITS(14), .LOG_MAX_AVG(16)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .dat_i  (dat_i),
    .trig_i (trig_i),
    .dat_o  (dat_o),
    .addr   (addr),
    .wen    (wen),
    .ren    (ren),
    .wdata  (wdata),
    .rdata  (rdata),
    .ack    (ack)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] sx(input logic [13:0] v);
    return {{18{v[13]}}, v};
  endfunction

  function automatic logic [31:0] mm(input logic [31:0] v);
`ifdef AVG_MINMAX_EN
    return v;
`else
    return (v & 32'h0);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] v);
    addr  = a;
    wdata = v;
    wen   = 1'b1;
    step();
    wen   = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] v);
    addr = a;
    ren  = 1'b1;
    step();
    ren  = 1'b0;
    v    = rdata;
    chk("rd_ack", {31'b0, ack}, 32'h1);
  endtask

  initial begin
    rst_i = 1'b1; dat_i = '0; trig_i = 1'b0;
    addr = '0; wen = 1'b0; ren = 1'b0; wdata = '0;
    repeat (2) step();
    chk("rst_dat_o", sx(dat_o), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ack", {31'b0, ack}, 32'h0);
    rst_i = 1'b0;
    rd(A_CTRL, d);  chk("rst_ctrl", d, 32'h0);
    rd(A_COUNT, d); chk("rst_count", d, 32'h0);
    rd(A_LOG2N, d); chk("rst_log2n", d, 32'h0);

    // Constant 1000, 16 samples
    dat_i = 14'sd1000;
    wr(A_LOG2N, 32'd4);
    wr(A_CTRL, 32'h1);
    repeat (15) step();
    chk("c_dat_o_early", sx(dat_o), 32'h0);
    rd(A_CTRL, d);   chk("c_busy_at_16", d, 32'h1);
    chk("c_dat_o", sx(dat_o), 32'd1000);
    rd(A_CTRL, d);   chk("c_done", d, 32'h4);
    rd(A_MEAN, d);   chk("c_mean", d, 32'd1000);
    rd(A_SUM_LO, d); chk("c_sum_lo", d, 32'd16000);
    rd(A_SUM_HI, d); chk("c_sum_hi", d, 32'h0);
    rd(A_MIN, d);    chk("c_min", d, mm(32'd1000));
    rd(A_MAX, d);    chk("c_max", d, mm(32'd1000));
    rd(A_COUNT, d);  chk("c_count", d, 32'd1);
    rd(A_CTRL, d);   chk("c_done_cleared", d, 32'h0);

    // Ramp -8..7
    wr(A_CTRL, 32'h1);
    for (int i = 0; i < 16; i++) begin
      dat_i = 14'(i - 8);
      step();
    end
    chk("r_dat_o", sx(dat_o), 32'hFFFF_FFFF);
    rd(A_MEAN, d);   chk("r_mean", d, 32'hFFFF_FFFF);
    rd(A_SUM_LO, d); chk("r_sum_lo", d, 32'hFFFF_FFF8);
    rd(A_SUM_HI, d); chk("r_sum_hi", d, 32'hFFFF_FFFF);
    rd(A_MIN, d);    chk("r_min", d, mm(32'hFFFF_FFF8));
    rd(A_MAX, d);    chk("r_max", d, mm(32'd7));
    rd(A_COUNT, d);  chk("r_count", d, 32'd2);

    // Abort at sample 5, then start+abort together in IDLE
    dat_i = 14'sd500;
    wr(A_CTRL, 32'h1);
    repeat (4) step();
    wr(A_CTRL, 32'h5);
    rd(A_CTRL, d);   chk("a_busy_off", d, 32'h0);
    wr(A_CTRL, 32'h5);
    rd(A_CTRL, d);   chk("a_start_ignored", d, 32'h0);
    repeat (20) step();
    rd(A_COUNT, d);  chk("a_count", d, 32'd2);
    rd(A_MEAN, d);   chk("a_mean", d, 32'hFFFF_FFFF);
    rd(A_SUM_LO, d); chk("a_sum_lo", d, 32'hFFFF_FFF8);
    chk("a_dat_o", sx(dat_o), 32'hFFFF_FFFF);

    // Negative full scale, LOG2N clamp, LOG2N change mid-window
    wr(A_LOG2N, 32'd20);
    rd(A_LOG2N, d);  chk("n_clamp", d, 32'd16);
    wr(A_LOG2N, 32'd12);
    dat_i = -14'sd8192;
    wr(A_CTRL, 32'h1);
    repeat (100) step();
    wr(A_LOG2N, 32'd2);
    repeat (3994) step();
    rd(A_CTRL, d);   chk("n_busy_at_4096", d, 32'h1);
    chk("n_dat_o", sx(dat_o), 32'hFFFF_E000);
    rd(A_MEAN, d);   chk("n_mean", d, 32'hFFFF_E000);
    rd(A_SUM_LO, d); chk("n_sum_lo", d, 32'hFE00_0000);
    rd(A_SUM_HI, d); chk("n_sum_hi", d, 32'hFFFF_FFFF);
    rd(A_MIN, d);    chk("n_min", d, mm(32'hFFFF_E000));
    rd(A_MAX, d);    chk("n_max", d, mm(32'hFFFF_E000));
    rd(A_COUNT, d);  chk("n_count", d, 32'd3);

    // External trigger, window of 4 (LOG2N=2 written during the previous window)
    wr(A_CTRL, 32'h8);
    dat_i  = 14'sd100;
    trig_i = 1'b1;
    step();
    trig_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      dat_i = 14'(100 * i);
      step();
    end
    chk("t_dat_o_early", sx(dat_o), 32'hFFFF_E000);
    dat_i = 14'sd400;
    step();
    chk("t_dat_o", sx(dat_o), 32'd250);
    rd(A_CTRL, d);   chk("t_ctrl", d, 32'hC);
    rd(A_SUM_LO, d); chk("t_sum_lo", d, 32'd1000);
    rd(A_MIN, d);    chk("t_min", d, mm(32'd100));
    rd(A_MAX, d);    chk("t_max", d, mm(32'd400));
    rd(A_COUNT, d);  chk("t_count", d, 32'd4);
    wr(A_CTRL, 32'h0);

    // Continuous, LOG2N=0: one window per cycle, COUNT wraps
    wr(A_LOG2N, 32'd0);
    wr(A_CTRL, 32'h3);
    dat_i = 14'sd5;
    step();
    chk("k_dat_o_5", sx(dat_o), 32'd5);
    dat_i = -14'sd3;
    step();
    chk("k_dat_o_m3", sx(dat_o), 32'hFFFF_FFFD);
    repeat (65529) step();
    rd(A_COUNT, d);  chk("k_count_ffff", d, 32'h0000_FFFF);
    rd(A_COUNT, d);  chk("k_count_wrap", d, 32'h0);
    wr(A_CTRL, 32'h4);
    rd(A_CTRL, d);   chk("k_ctrl_after_abort", d, 32'h4);
    rd(A_COUNT, d);  chk("k_count_after_abort", d, 32'd1);

    // Unmapped and reserved offsets
    rd(16'h0200, d); chk("u_rdata", d, 32'h0);
    addr = 16'h0004;
    ren  = 1'b1;
    step();
    ren  = 1'b0;
    chk("u_reserved_ack", {31'b0, ack}, 32'h0);
    chk("u_reserved_rdata", rdata, 32'h0);

    // Reset in the middle of a window
    wr(A_LOG2N, 32'd4);
    dat_i = 14'sd7;
    wr(A_CTRL, 32'h9);
    repeat (2) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("x_dat_o", sx(dat_o), 32'h0);
    chk("x_ack", {31'b0, ack}, 32'h0);
    chk("x_rdata", rdata, 32'h0);
    repeat (20) step();
    rd(A_CTRL, d);   chk("x_ctrl", d, 32'h0);
    rd(A_COUNT, d);  chk("x_count", d, 32'h0);
    rd(A_MEAN, d);   chk("x_mean", d, 32'h0);
    rd(A_SUM_LO, d); chk("x_sum_lo", d, 32'h0);
    rd(A_LOG2N, d);  chk("x_log2n", d, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
